// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Main control FSM of the multi-cycle MIPS core; one state per
//               cycle, memory-ready handshake stalls fetch and data accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [OP_W-1:0] c_op_rtype = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] c_op_lw    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] c_op_sw    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] c_op_beq   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] c_op_bne   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] c_op_addi  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] c_op_j     = OP_W'(6'b000010);

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       fetch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Moore output set of a state; registered together with the state itself.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.memread = 1'b1; c.fetch = 1'b1; c.alusrcb = 2'b01; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   begin c.iord = 1'b1; c.memread = 1'b1; end
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.jump = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_op_legal;
  logic   w_pcwrite;
  logic   w_take;

  assign w_op_legal = (Op == c_op_rtype) || (Op == c_op_lw)  || (Op == c_op_sw) ||
                      (Op == c_op_beq)   || (Op == c_op_bne) || (Op == c_op_addi) ||
                      (Op == c_op_j);

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = MemReady ? DECODE : FETCH;
      DECODE: begin
        if ((Op == c_op_lw) || (Op == c_op_sw))       w_next = MEMADR;
        else if (Op == c_op_rtype)                     w_next = EXECUTE;
        else if ((Op == c_op_beq) || (Op == c_op_bne)) w_next = BRANCH;
        else if (Op == c_op_addi)                      w_next = ADDIEX;
        else if (Op == c_op_j)                         w_next = JUMP;
        else                                           w_next = FETCH;
      end
      MEMADR:  w_next = (Op == c_op_sw) ? MEMWR : MEMRD;
      MEMRD:   w_next = MemReady ? MEMWB : MEMRD;
      MEMWB:   w_next = FETCH;
      MEMWR:   w_next = MemReady ? FETCH : MEMWR;
      EXECUTE: w_next = ALUWB;
      ALUWB:   w_next = FETCH;
      BRANCH:  w_next = FETCH;
      ADDIEX:  w_next = ADDIWB;
      ADDIWB:  w_next = FETCH;
      JUMP:    w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_ctrl  <= ctrl_of(FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
    end
  end

  // Requests and enables are masked by rst_n so an aborted access stops at once.
  assign w_pcwrite = (r_ctrl.fetch & MemReady) | r_ctrl.jump;
  assign w_take    = r_ctrl.branch & (((Op == c_op_beq) & Zero) | ((Op == c_op_bne) & ~Zero));

  assign IorD      = r_ctrl.iord;
  assign MemRead   = r_ctrl.memread & rst_n;
  assign MemWrite  = r_ctrl.memwrite & rst_n;
  assign IRWrite   = r_ctrl.fetch & MemReady & rst_n;
  assign RegDst    = r_ctrl.regdst;
  assign MemtoReg  = r_ctrl.memtoreg;
  assign RegWrite  = r_ctrl.regwrite & rst_n;
  assign ALUSrcA   = r_ctrl.alusrca;
  assign ALUSrcB   = r_ctrl.alusrcb;
  assign ALUOp     = r_ctrl.aluop;
  assign PCSrc     = r_ctrl.pcsrc;
  assign PCEn      = rst_n & (w_pcwrite | w_take);
  assign IllegalOp = rst_n & (r_state == DECODE) & ~w_op_legal;
  assign State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed scoreboard bench for the multi-cycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, IllegalOp;
  logic [3:0] State;

  mips_multicycle_ctrl #(.OP_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] c_rtype = 6'b000000, c_lw = 6'b100011, c_sw = 6'b101011,
                         c_beq = 6'b000100, c_bne = 6'b000101, c_addi = 6'b001000,
                         c_j = 6'b000010, c_bad = 6'b111111;

  localparam logic [3:0] s_fetch = 4'd0, s_decode = 4'd1, s_memadr = 4'd2, s_memrd = 4'd3,
                         s_memwb = 4'd4, s_memwr = 4'd5, s_execute = 4'd6, s_aluwb = 4'd7,
                         s_branch = 4'd8, s_addiex = 4'd9, s_addiwb = 4'd10, s_jump = 4'd11;

  // Bit order: IorD MemRead MemWrite IRWrite | RegDst MemtoReg RegWrite ALUSrcA |
  //            ALUSrcB ALUOp | PCSrc PCEn IllegalOp
  localparam logic [15:0] c_v_rst    = 16'b0000_0000_0100_0000;
  localparam logic [15:0] c_v_fetch1 = 16'b0101_0000_0100_0010;
  localparam logic [15:0] c_v_fetch0 = 16'b0100_0000_0100_0000;
  localparam logic [15:0] c_v_decode = 16'b0000_0000_1100_0000;
  localparam logic [15:0] c_v_dec_il = 16'b0000_0000_1100_0001;
  localparam logic [15:0] c_v_memadr = 16'b0000_0001_1000_0000;
  localparam logic [15:0] c_v_memrd  = 16'b1100_0000_0000_0000;
  localparam logic [15:0] c_v_memwb  = 16'b0000_0110_0000_0000;
  localparam logic [15:0] c_v_memwr  = 16'b1010_0000_0000_0000;
  localparam logic [15:0] c_v_exec   = 16'b0000_0001_0010_0000;
  localparam logic [15:0] c_v_aluwb  = 16'b0000_1010_0000_0000;
  localparam logic [15:0] c_v_br_t   = 16'b0000_0001_0001_0110;
  localparam logic [15:0] c_v_br_n   = 16'b0000_0001_0001_0100;
  localparam logic [15:0] c_v_addiex = 16'b0000_0001_1000_0000;
  localparam logic [15:0] c_v_addiwb = 16'b0000_0010_0000_0000;
  localparam logic [15:0] c_v_jump   = 16'b0000_0000_0000_1010;

  typedef struct packed {
    logic [31:0] id;
    logic [3:0]  st;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_step = 0;

  // One cycle of stimulus plus the outputs expected while it is applied.
  task automatic step(input logic rn, input logic [5:0] op, input logic z,
                      input logic mr, input logic [3:0] st, input logic [15:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; Op = op; Zero = z; MemReady = mr;
    n_step++;
    e.id = 32'(n_step); e.st = st; e.v = v;
    q.push_back(e);
  endtask

  // Monitor: compares every cycle for which an expectation is queued.
  always @(negedge clk) begin
    exp_t       e;
    logic [19:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {State, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp};
      checks++;
      if (act !== {e.st, e.v}) begin
        errors++;
        $display("FAIL step%0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 e.id, act[19:16], act[15:0], e.st, e.v);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    step(0, c_lw, 0, 1, s_fetch, c_v_rst);
    // LW, no waits
    step(1, c_lw, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_lw, 0, 1, s_decode, c_v_decode);
    step(1, c_lw, 0, 1, s_memadr, c_v_memadr);
    step(1, c_lw, 0, 1, s_memrd,  c_v_memrd);
    step(1, c_lw, 0, 1, s_memwb,  c_v_memwb);
    // R-type
    step(1, c_rtype, 0, 1, s_fetch,   c_v_fetch1);
    step(1, c_rtype, 0, 1, s_decode,  c_v_decode);
    step(1, c_rtype, 0, 1, s_execute, c_v_exec);
    step(1, c_rtype, 0, 1, s_aluwb,   c_v_aluwb);
    // Branches
    step(1, c_beq, 1, 1, s_fetch,  c_v_fetch1);
    step(1, c_beq, 1, 1, s_decode, c_v_decode);
    step(1, c_beq, 1, 1, s_branch, c_v_br_t);
    step(1, c_beq, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_beq, 0, 1, s_decode, c_v_decode);
    step(1, c_beq, 0, 1, s_branch, c_v_br_n);
    step(1, c_bne, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_bne, 0, 1, s_decode, c_v_decode);
    step(1, c_bne, 0, 1, s_branch, c_v_br_t);
    step(1, c_bne, 1, 1, s_fetch,  c_v_fetch1);
    step(1, c_bne, 1, 1, s_decode, c_v_decode);
    step(1, c_bne, 1, 1, s_branch, c_v_br_n);
    // SW with fetch stall of 2 and write stall of 3
    step(1, c_sw, 0, 0, s_fetch,  c_v_fetch0);
    step(1, c_sw, 0, 0, s_fetch,  c_v_fetch0);
    step(1, c_sw, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_sw, 0, 1, s_decode, c_v_decode);
    step(1, c_sw, 0, 1, s_memadr, c_v_memadr);
    step(1, c_sw, 0, 0, s_memwr,  c_v_memwr);
    step(1, c_sw, 0, 0, s_memwr,  c_v_memwr);
    step(1, c_sw, 0, 0, s_memwr,  c_v_memwr);
    step(1, c_sw, 0, 1, s_memwr,  c_v_memwr);
    // ADDI
    step(1, c_addi, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_addi, 0, 1, s_decode, c_v_decode);
    step(1, c_addi, 0, 1, s_addiex, c_v_addiex);
    step(1, c_addi, 0, 1, s_addiwb, c_v_addiwb);
    // Illegal opcode, then J
    step(1, c_bad, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_bad, 0, 1, s_decode, c_v_dec_il);
    step(1, c_j,   0, 1, s_fetch,  c_v_fetch1);
    step(1, c_j,   0, 1, s_decode, c_v_decode);
    step(1, c_j,   0, 1, s_jump,   c_v_jump);
    // LW with one MEMRD wait
    step(1, c_lw, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_lw, 0, 1, s_decode, c_v_decode);
    step(1, c_lw, 0, 1, s_memadr, c_v_memadr);
    step(1, c_lw, 0, 0, s_memrd,  c_v_memrd);
    step(1, c_lw, 0, 1, s_memrd,  c_v_memrd);
    step(1, c_lw, 0, 1, s_memwb,  c_v_memwb);
    // Reset asserted mid-MEMWR while memory is stalled
    step(1, c_sw, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_sw, 0, 1, s_decode, c_v_decode);
    step(1, c_sw, 0, 1, s_memadr, c_v_memadr);
    step(1, c_sw, 0, 0, s_memwr,  c_v_memwr);
    step(0, c_sw, 0, 0, s_fetch,  c_v_rst);
    step(1, c_sw, 0, 1, s_fetch,  c_v_fetch1);
    step(1, c_sw, 0, 1, s_decode, c_v_decode);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
